// File: rtl/contador_rst.sv
// Modulo-(MAX+1) up-counter with synchronous active-high reset and count enable.
// Define CONTADOR_RST_TC_EN to add the combinational terminal-count output Tc.
module contador_rst #(
   parameter int WIDTH = 4,
   parameter int MAX   = 9
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             En,
   output logic [WIDTH-1:0] Out
`ifdef CONTADOR_RST_TC_EN
   ,
   output logic             Tc
`endif
);

   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

   if (WIDTH < 1 || WIDTH > 31) begin : g_bad_width
      $error("contador_rst: WIDTH=%0d out of supported range 1..31", WIDTH);
   end

   if (MAX < 1 || MAX > (2 ** WIDTH) - 1) begin : g_bad_max
      $error("contador_rst: MAX=%0d must lie in 1..2**WIDTH-1", MAX);
   end

   // Using >= rather than == also recovers a power-up value above MAX.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         Out <= '0;
      end else if (En) begin
         if (Out >= MAX_V) begin
            Out <= '0;
         end else begin
            Out <= Out + WIDTH'(1);
         end
      end
   end

`ifdef CONTADOR_RST_TC_EN
   // High during the cycle whose rising edge performs the wrap to 0.
   assign Tc = En & ~Rst & (Out == MAX_V);
`endif

endmodule

// File: tb/tb_contador_rst.sv
// Self-checking bench for contador_rst: two instances (4-bit/MAX 9 and 3-bit/MAX 7)
// driven by shared Rst/En and compared against a modular-arithmetic reference model.
module tb_contador_rst;

   localparam int MAX_A = 9;
   localparam int MAX_B = 7;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en  = 1'b0;
   logic [3:0] out_a;
   logic [2:0] out_b;
`ifdef CONTADOR_RST_TC_EN
   logic       tc_a;
   logic       tc_b;
`endif

   int checks   = 0;
   int failures = 0;
   int mdl_a    = 0;
   int mdl_b    = 0;

   always #5 clk = ~clk;

   contador_rst #(.WIDTH(4), .MAX(MAX_A)) u_dut_a (
      .Clk (clk),
      .Rst (rst),
      .En  (en),
      .Out (out_a)
`ifdef CONTADOR_RST_TC_EN
      ,
      .Tc  (tc_a)
`endif
   );

   contador_rst #(.WIDTH(3), .MAX(MAX_B)) u_dut_b (
      .Clk (clk),
      .Rst (rst),
      .En  (en),
      .Out (out_b)
`ifdef CONTADOR_RST_TC_EN
      ,
      .Tc  (tc_b)
`endif
   );

   task automatic check_val(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Called at a falling edge: drives inputs, checks Tc ahead of the edge,
   // advances the model on the rising edge, checks Out at the next falling edge.
   task automatic cycle(input logic r, input logic e, input string tag);
      rst = r;
      en  = e;
      #1;
`ifdef CONTADOR_RST_TC_EN
      check_val({tag, "_tc_a"}, int'(tc_a), int'(e && !r && mdl_a == MAX_A));
      check_val({tag, "_tc_b"}, int'(tc_b), int'(e && !r && mdl_b == MAX_B));
`endif
      @(posedge clk);
      if (r) begin
         mdl_a = 0;
         mdl_b = 0;
      end else if (e) begin
         mdl_a = (mdl_a + 1) % (MAX_A + 1);
         mdl_b = (mdl_b + 1) % (MAX_B + 1);
      end
      @(negedge clk);
      check_val({tag, "_out_a"}, int'(out_a), mdl_a);
      check_val({tag, "_out_b"}, int'(out_b), mdl_b);
   endtask

   initial begin
      @(negedge clk);

      // Reset from unknown state with En high, held for two edges.
      cycle(1'b1, 1'b1, "rst0");
      check_val("rst0_zero", int'(out_a), 0);
      cycle(1'b1, 1'b1, "rst1");
      check_val("rst1_zero", int'(out_a), 0);

      // Full sequence: A runs 1..9,0,1,2; B runs 1..7,0,1,...
      for (int i = 0; i < 12; i++) begin
         cycle(1'b0, 1'b1, "seq");
         check_val("seq_exp_a", int'(out_a), (i + 1) % 10);
         check_val("seq_exp_b", int'(out_b), (i + 1) % 8);
      end

      // Hold at 5 for four disabled edges, then resume to 6.
      cycle(1'b1, 1'b0, "hold_rst");
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, "hold_up");
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, 1'b0, "hold");
         check_val("hold_exp", int'(out_a), 5);
      end
      cycle(1'b0, 1'b1, "hold_go");
      check_val("hold_go_exp", int'(out_a), 6);

      // Reset mid-count at 7 wins over En, then count resumes from 0.
      cycle(1'b1, 1'b0, "mid_rst");
      for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, "mid_up");
      check_val("mid_at7", int'(out_a), 7);
      cycle(1'b1, 1'b1, "mid_hit");
      check_val("mid_zero", int'(out_a), 0);
      cycle(1'b0, 1'b1, "mid_one");
      check_val("mid_one_exp", int'(out_a), 1);

      // Terminal count: hold at 9 with En low, then wrap with En high.
      cycle(1'b1, 1'b0, "tc_rst");
      for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1, "tc_up");
      check_val("tc_at9", int'(out_a), 9);
      cycle(1'b0, 1'b0, "tc_hold");
      check_val("tc_hold_exp", int'(out_a), 9);
`ifdef CONTADOR_RST_TC_EN
      rst = 1'b0;
      en  = 1'b1;
      #1;
      check_val("tc_high", int'(tc_a), 1);
`endif
      cycle(1'b0, 1'b1, "tc_wrap");
      check_val("tc_wrap_exp", int'(out_a), 0);

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         cycle(logic'($urandom_range(0, 15) == 0), logic'($urandom_range(0, 1)), "rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
